fir_ntap_pipe: RTL and testbench
================================

# fir_ntap_pipe

Parametrised, fully pipelined N-tap FIR filter with runtime-programmable signed coefficients, valid-qualified input/output and a saturating scaled output. It is the next generation of our fixed 4-tap unit-coefficient adder-tree FIR. It keeps that block's sample delay line and summing datapath, and generalises them to TAPS taps with a registered binary adder tree. With all coefficients at their reset value of 1, it computes the same moving sum as the fixed block.

## Interface
- W, 16: input sample width, signed two's complement.
- CW, 8: coefficient width, signed.
- TAPS, 8: tap count; must be a power of 2 in the range 2..32. LG = log2(TAPS).
- SHIFT, 0: arithmetic right shift applied to the full-precision sum before saturation; range 0..CW+LG.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  in_data is sampled on this clock edge.
- in_data  in  W  signed input sample.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  LG  tap index to write; 0 is the newest sample.
- coef_data  in  CW  signed coefficient value.
- out_valid  out  1  out_data and out_sat are valid this cycle.
- out_data  out  W  signed, scaled and saturated filter output.
- out_sat  out  1  out_data was clipped for this output.

## Operation
- Delay line: x[0..TAPS-1] holds W-bit registers. On an edge where in_valid=1: x[0] <= in_data and x[i] <= x[i-1]. On an edge where in_valid=0, all taps hold.
- Coefficients: c[0..TAPS-1] are CW-bit registers. On an edge where coef_we=1: c[coef_addr] <= coef_data. Writes are accepted every cycle, independent of in_valid.
- Product stage: on the same edge that shifts the delay line, p[i] <= x_next[i] * c[i], where x_next is the post-shift tap value.
  - p[i] is a signed (W+CW)-bit register.
  - c[i] is the value held before that edge, so a write in cycle t applies only to samples accepted in cycles after t.
  - The product stage holds when in_valid=0.
- Adder tree: LG registered stages, with stage k summing pairs from stage k-1.
  - Stage k is W+CW+k bits wide and sign-extended; no intermediate truncation.
  - Full sum width FW = W+CW+LG. Tree stages advance every cycle, whether or not valid data is present.
- Output: y = full_sum >>> SHIFT, an arithmetic shift that floors toward minus infinity.
  - If y > 2^(W-1)-1: out_data = 2^(W-1)-1 and out_sat=1.
  - If y < -2^(W-1): out_data = -2^(W-1) and out_sat=1.
  - Otherwise out_data = y[W-1:0] and out_sat=0.
  - Saturation is combinational on the final tree register; out_data is not separately registered.
- Valid tracking: a (1+LG)-bit shift register carries in_valid alongside the datapath. out_valid is its last stage.
- out_data and out_sat are meaningful only while out_valid=1. Between valids they show stale tree contents; the bench must ignore them.
- No backpressure: the output must be consumed in the cycle it is presented.

## Timing
- Latency: a sample accepted in cycle t appears with out_valid=1 in cycle t+1+LG. For TAPS=8 that is cycle t+4.
- Throughput: one sample per cycle. Back-to-back valids produce back-to-back out_valids.
- Gaps in in_valid appear as identical gaps in out_valid. The filter state (delay line) is not advanced by invalid cycles.
- Reset values:
  - x, p, tree registers and the valid pipe = 0.
  - c[i] = 1 for all i, giving a unit-coefficient moving sum.
  - out_valid=0, out_data=0, out_sat=0 in the cycle after reset is sampled.
- Reset mid-operation: all in-flight results are discarded and no out_valid occurs until new samples are accepted. Coefficient writes and samples presented in the reset cycle are ignored.
- coef_we and in_valid in the same cycle: the sample uses the old coefficient, and the new coefficient applies from the next accepted sample.

## Test plan
- Reset defaults: assert reset 2 cycles with in_valid=1 and coef_we=1 -> out_valid stays 0, and c reads back all 1 via impulse response. The impulse is in_data=100 then 7 samples of 0 -> 8 consecutive outputs of 100, then 0.
- Coefficient load and latency: write c = {1,-2,3,-4,5,-6,7,-8} (TAPS=8, SHIFT=0), then impulse in_data=10 at cycle t.
  - Required: out_valid first in cycle t+4, with outputs 10,-20,30,-40,50,-60,70,-80, then 0.
- Saturation: W=16, CW=8, all c=127, 8 consecutive samples of 32767 -> final out_data=32767, out_sat=1.
  - Repeat with -32768 -> out_data=-32768, out_sat=1.
  - With SHIFT=10 and all c=1, the sum of eight 1024 samples (8192) -> out_data=8, out_sat=0.
- Bubbles: unit coefficients, sample pattern 1,2,3,4 with 3 idle cycles after each sample -> outputs 1,3,6,10. Each output is separated by 3 idle cycles, and idle cycles do not shift the taps.
- Write/sample collision: in the same cycle write c[0]=5 and accept in_data=2 (other taps 0) -> that output = 2. The next sample 2 -> output 10+2 = 12 with unit c[1].
- Reset mid-stream: reset asserted 2 cycles after 3 valid samples -> no out_valid for those samples. After release, out_valid appears only 4 cycles after the next accepted sample.

Source files
------------

// File: rtl/fir_ntap_pipe.sv
// fir_ntap_pipe: TAPS-tap FIR with per-tap programmable signed coefficients.
// Each tap owns its delay-line stage, coefficient and product register. The
// products feed a registered binary adder tree that grows one bit per level,
// followed by an arithmetic right shift and saturation to W bits.
// in_valid travels alongside the datapath in a shift register. With every
// coefficient at its reset value of 1, the block computes a plain moving sum.

// One tap: delay stage, coefficient register and registered product.
// The product uses the post-shift sample and the coefficient value held
// before the edge. A coefficient written in the same cycle as a sample
// therefore applies from the next accepted sample onward.
module fir_tap_mac #(
  parameter int W  = 16,
  parameter int CW = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic signed [W-1:0]  x_in,
  input  logic                 coef_we,
  input  logic signed [CW-1:0] coef_data,
  output logic [W-1:0]         x_q,
  output logic [W+CW-1:0]      p_q
);
  logic signed [CW-1:0]   c_q;
  logic signed [W+CW-1:0] prod;

  // Both operands are sign-extended to full width, so the product is exact.
  assign prod = (W+CW)'(x_in) * (W+CW)'(c_q);

  // Delay stage and product advance only on accepted samples.
  // Coefficient writes are accepted every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      p_q <= '0;
      c_q <= CW'(1);
    end else begin
      if (en) begin
        x_q <= x_in;
        p_q <= prod;
      end
      if (coef_we) c_q <= coef_data;
    end
  end
endmodule

module fir_ntap_pipe #(
  parameter int W     = 16,
  parameter int CW    = 8,
  parameter int TAPS  = 8,
  parameter int SHIFT = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [W-1:0]             in_data,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [CW-1:0]            coef_data,
  output logic                     out_valid,
  output logic [W-1:0]             out_data,
  output logic                     out_sat
);
  localparam int LG = $clog2(TAPS);
  localparam int FW = W + CW + LG;

  // Saturation bounds, sign-extended to full precision.
  localparam logic signed [FW-1:0] YMAX = {{(FW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [FW-1:0] YMIN = {{(FW-W+1){1'b1}}, {(W-1){1'b0}}};

  logic [TAPS-1:0][W-1:0]    x_q;
  logic [TAPS-1:0][W+CW-1:0] p_q;
  logic [LG:0]               vld_pipe;

  genvar i, k;

  // Per-tap lanes. Tap 0 takes the new sample; tap i takes tap i-1's value.
  generate
    for (i = 0; i < TAPS; i++) begin : g_tap
      logic [W-1:0] x_in;
      if (i == 0) begin : g_head
        assign x_in = in_data;
      end else begin : g_chain
        assign x_in = x_q[i-1];
      end
      fir_tap_mac #(.W(W), .CW(CW)) u_tap (
        .clk       (clk),
        .reset     (reset),
        .en        (in_valid),
        .x_in      ($signed(x_in)),
        .coef_we   (coef_we && (coef_addr == LG'(i))),
        .coef_data ($signed(coef_data)),
        .x_q       (x_q[i]),
        .p_q       (p_q[i])
      );
    end
  endgenerate

  // Adder tree: level k halves the operand count and adds one bit. No
  // truncation is applied, and each level advances every cycle.
  generate
    for (k = 1; k <= LG; k++) begin : g_lvl
      localparam int N  = TAPS >> k;
      localparam int SW = W + CW + k;
      logic [N-1:0][SW-1:0]     s;
      logic [2*N-1:0][SW-2:0]   src;
      if (k == 1) begin : g_src_p
        assign src = p_q;
      end else begin : g_src_lvl
        assign src = g_lvl[k-1].s;
      end
      // Sign-extend each pair and register the sum.
      always_ff @(posedge clk) begin
        if (reset) begin
          s <= '0;
        end else begin
          for (int j = 0; j < N; j++)
            s[j] <= SW'($signed(src[2*j])) + SW'($signed(src[2*j+1]));
        end
      end
    end
  endgenerate

  // in_valid rides alongside the product stage and each tree level.
  always_ff @(posedge clk) begin
    if (reset) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[LG-1:0], in_valid};
  end

  logic signed [FW-1:0] full_sum;
  logic signed [FW-1:0] y;

  assign full_sum  = $signed(g_lvl[LG].s[0]);
  assign y         = full_sum >>> SHIFT;
  assign out_valid = vld_pipe[LG];

  // Clip the scaled sum to the W-bit signed range and flag any clipping.
  always_comb begin
    out_data = y[W-1:0];
    out_sat  = 1'b0;
    if (y > YMAX) begin
      out_data = {1'b0, {(W-1){1'b1}}};
      out_sat  = 1'b1;
    end else if (y < YMIN) begin
      out_data = {1'b1, {(W-1){1'b0}}};
      out_sat  = 1'b1;
    end
  end
endmodule

// File: tb/tb_fir_ntap_pipe.sv
// Bench for fir_ntap_pipe (W=16, CW=8, TAPS=8). Two instances share the same
// stimulus: one with SHIFT=0 and one with SHIFT=10. The reference model keeps
// the accepted-sample history and the coefficient table as integers. For each
// accepted sample it forms the dot product and pushes the expected result,
// tagged with its due edge, into a queue. A negedge monitor pops entries and
// checks both instances. In all other cycles it requires out_valid=0.
module tb_fir_ntap_pipe;
  localparam int LG = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [15:0]       in_data;
  logic              coef_we;
  logic [2:0]        coef_addr;
  logic [7:0]        coef_data;
  logic              ov0, ov1, os0, os1;
  logic [15:0]       od0, od1;

  fir_ntap_pipe #(.W(16), .CW(8), .TAPS(8), .SHIFT(0)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(ov0), .out_data(od0), .out_sat(os0));

  fir_ntap_pipe #(.W(16), .CW(8), .TAPS(8), .SHIFT(10)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(ov1), .out_data(od1), .out_sat(os1));

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int d0;
    bit s0;
    int d10;
    bit s10;
  } exp_t;

  exp_t q[$];
  int   hist[8];
  int   cf[8];
  int   edges = 0;
  int   tests = 0;
  int   fails = 0;
  bit   started = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d (edge %0d)", name, act, exp, edges);
    end
  endtask

  function automatic void scale_sat(input longint acc, input int sh,
                                    output int d, output bit s);
    longint yv;
    yv = acc >>> sh;
    if (yv > 32767) begin
      d = 32767;  s = 1'b1;
    end else if (yv < -32768) begin
      d = -32768; s = 1'b1;
    end else begin
      d = int'(yv); s = 1'b0;
    end
  endfunction

  // Drive one cycle, then update the model with what the edge accepted.
  task automatic step(input bit rst, input bit vi, input int d,
                      input bit we, input int a, input int cd);
    longint acc;
    exp_t   e;
    reset = rst; in_valid = vi; in_data = 16'(d);
    coef_we = we; coef_addr = 3'(a); coef_data = 8'(cd);
    @(posedge clk);
    #1;
    edges++;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin hist[i] = 0; cf[i] = 1; end
      q.delete();
    end else begin
      if (vi) begin
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = d;
        acc = 0;
        for (int i = 0; i < 8; i++) acc += longint'(hist[i]) * longint'(cf[i]);
        e.due = edges + LG;
        scale_sat(acc, 0,  e.d0,  e.s0);
        scale_sat(acc, 10, e.d10, e.s10);
        q.push_back(e);
      end
      if (we) cf[a] = cd;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic sample(input int d);
    step(0, 1, d, 0, 0, 0);
  endtask

  task automatic set_all_coefs(input int v);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, i, v);
  endtask

  // Each cycle, either an expected result is due and both instances must
  // present it, or neither instance may assert out_valid.
  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      if (q.size() > 0 && q[0].due == edges) begin
        e = q.pop_front();
        chk("valid0", int'(ov0), 1);
        chk("valid1", int'(ov1), 1);
        chk("data_sh0", int'($signed(od0)), e.d0);
        chk("sat_sh0", int'(os0), int'(e.s0));
        chk("data_sh10", int'($signed(od1)), e.d10);
        chk("sat_sh10", int'(os1), int'(e.s10));
      end else begin
        chk("idle_valid0", int'(ov0), 0);
        chk("idle_valid1", int'(ov1), 0);
      end
    end
  end

  initial begin
    // Reset with in_valid and coef_we active; both must be ignored.
    step(1, 1, 1234, 1, 3, -5);
    started = 1;
    chk("rst_valid", int'(ov0), 0);
    chk("rst_data", int'(od0), 0);
    chk("rst_sat", int'(os0), 0);
    step(1, 1, 999, 1, 0, 9);
    // Impulse through unit coefficients: eight 100s, then 0.
    sample(100);
    for (int i = 0; i < 8; i++) sample(0);
    idle(5);

    // Signed coefficient load, then an impulse of 10.
    for (int i = 0; i < 8; i++)
      step(0, 0, 0, 1, i, (i % 2 == 0) ? (i + 1) : -(i + 1));
    sample(10);
    for (int i = 0; i < 8; i++) sample(0);
    idle(5);

    // Saturation at both rails.
    set_all_coefs(127);
    for (int i = 0; i < 8; i++) sample(32767);
    for (int i = 0; i < 8; i++) sample(-32768);
    idle(5);

    // Unit coefficients, history cleared, then eight samples of 1024.
    set_all_coefs(1);
    for (int i = 0; i < 8; i++) sample(0);
    for (int i = 0; i < 8; i++) sample(1024);
    for (int i = 0; i < 8; i++) sample(0);
    idle(5);

    // Bubbles: idle cycles must not shift the taps.
    for (int s = 1; s <= 4; s++) begin
      sample(s);
      idle(3);
    end
    for (int i = 0; i < 8; i++) sample(0);
    idle(5);

    // A write and a sample in the same cycle: the sample uses the old c[0].
    step(0, 1, 2, 1, 0, 5);
    sample(2);
    for (int i = 0; i < 8; i++) sample(0);
    idle(5);

    // Reset while three results are still in flight.
    set_all_coefs(1);
    sample(11); sample(22); sample(33);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 44, 1, 1, 3);
    idle(6);
    sample(7);
    idle(8);

    // Randomised traffic with sparse coefficient writes and resets.
    for (int n = 0; n < 600; n++) begin
      bit rst, vi, we;
      rst = ($urandom_range(0, 99) < 2);
      vi  = ($urandom_range(0, 99) < 70);
      we  = ($urandom_range(0, 99) < 10);
      step(rst, vi, $urandom_range(0, 65535) - 32768,
           we, $urandom_range(0, 7), $urandom_range(0, 255) - 128);
    end

    idle(10);
    chk("drain_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
